// File: rtl/interrupt_sequencer_pkg.sv
// rtl/interrupt_sequencer_pkg.sv - shared sequencer state encodings and helpers
package interrupt_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACK    = 3'd1,
    VECTOR = 3'd2,
    ISR    = 3'd3,
    RETURN = 3'd4
  } seq_state_t;

  localparam int PC_WIDTH_DEFAULT = 8;

  // True for every state in which the CPU is considered to be servicing an interrupt
  function automatic logic state_in_isr(input seq_state_t s);
    return (s == VECTOR) || (s == ISR) || (s == RETURN);
  endfunction

  // True for states that must freeze fetch/decode
  function automatic logic state_stalls(input seq_state_t s);
    return (s == ACK) || (s == VECTOR) || (s == RETURN);
  endfunction

endpackage

// File: rtl/pc_save_reg.sv
// rtl/pc_save_reg.sv - width-parameterised load/clear register for PC values
module pc_save_reg #(
  parameter int pcWidth = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               load,
  input  logic [pcWidth-1:0] d,
  output logic [pcWidth-1:0] q
);

  // Clear wins over load so a reset always leaves the register at zero
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - CPU-side take/vector/return sequencer for the HVPI controller
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter int pcWidth = PC_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               intPending,
  input  logic [pcWidth-1:0] isrAddr,
  input  logic               instrDone,
  input  logic [pcWidth-1:0] pcIn,
  input  logic               retiExec,
  input  logic               eiExec,
  input  logic               diExec,
  output logic               intDisable,
  output logic               ldIntReg,
  output logic               clrIntReg,
  output logic               clrPend,
  output logic               stall,
  output logic               pcLoad,
  output logic [pcWidth-1:0] pcOut,
  output logic               inIsr
);

  seq_state_t         state;
  seq_state_t         state_next;
  logic               gie;
  logic               take_int;
  logic               load_vec;
  logic [pcWidth-1:0] saved_pc;
  logic [pcWidth-1:0] vec_reg;

  // A DI in the same cycle as the boundary must win, so it vetoes the take directly
  assign take_int = (state == IDLE) && intPending && gie && instrDone && !diExec;
  assign load_vec = (state == ACK);

  pc_save_reg #(.pcWidth(pcWidth)) u_saved_pc (
    .clk  (clk),
    .clr  (rst),
    .load (take_int),
    .d    (pcIn),
    .q    (saved_pc)
  );

  pc_save_reg #(.pcWidth(pcWidth)) u_vec_reg (
    .clk  (clk),
    .clr  (rst),
    .load (load_vec),
    .d    (isrAddr),
    .q    (vec_reg)
  );

  // Global interrupt enable; DI beats EI, and it tracks EI/DI in every state
  always_ff @(posedge clk) begin
    if (rst) begin
      gie <= 1'b0;
    end else if (diExec) begin
      gie <= 1'b0;
    end else if (eiExec) begin
      gie <= 1'b1;
    end
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; RETI outside ISR is ignored
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (take_int) state_next = ACK;
      ACK:     state_next = VECTOR;
      VECTOR:  state_next = ISR;
      ISR:     if (retiExec) state_next = RETURN;
      RETURN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore output decode; the HVPI clear strobes are also forced during reset
  always_comb begin
    intDisable = !gie || (state != IDLE);
    ldIntReg   = (state == IDLE);
    clrIntReg  = rst || (state == VECTOR);
    clrPend    = rst || (state == VECTOR);
    stall      = state_stalls(state);
    pcLoad     = (state == VECTOR) || (state == RETURN);
    inIsr      = state_in_isr(state);
    pcOut      = '0;
    if (state == VECTOR) begin
      pcOut = vec_reg;
    end else if (state == RETURN) begin
      pcOut = saved_pc;
    end
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb/tb_interrupt_sequencer.sv - directed scoreboard bench for interrupt_sequencer
module tb_interrupt_sequencer;

  typedef struct {
    logic [7:0] pc;
    int         lat;
  } exp_load_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       intPending;
  logic [7:0] isrAddr;
  logic       instrDone;
  logic [7:0] pcIn;
  logic       retiExec;
  logic       eiExec;
  logic       diExec;
  logic       intDisable;
  logic       ldIntReg;
  logic       clrIntReg;
  logic       clrPend;
  logic       stall;
  logic       pcLoad;
  logic [7:0] pcOut;
  logic       inIsr;

  int checks = 0;
  int failures = 0;
  exp_load_t sb[$];

  interrupt_sequencer #(.pcWidth(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .intPending (intPending),
    .isrAddr    (isrAddr),
    .instrDone  (instrDone),
    .pcIn       (pcIn),
    .retiExec   (retiExec),
    .eiExec     (eiExec),
    .diExec     (diExec),
    .intDisable (intDisable),
    .ldIntReg   (ldIntReg),
    .clrIntReg  (clrIntReg),
    .clrPend    (clrPend),
    .stall      (stall),
    .pcLoad     (pcLoad),
    .pcOut      (pcOut),
    .inIsr      (inIsr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the next PC load and compares it with the oldest scoreboard entry.
  // The call is made just after the triggering edge, so the first cycle counts as latency 1.
  task automatic wait_pcload(input string tag);
    exp_load_t e;
    int        lat;
    lat = 1;
    while (!pcLoad && lat < 8) begin
      tick();
      lat++;
    end
    chk({tag, "_seen"}, pcLoad, 1'b1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_pcOut"}, pcOut, e.pc);
      chk({tag, "_latency"}, lat, e.lat);
    end
  endtask

  initial begin
    logic seen;
    rst = 1'b1; intPending = 1'b0; isrAddr = 8'h00; instrDone = 1'b0; pcIn = 8'h00;
    retiExec = 1'b0; eiExec = 1'b0; diExec = 1'b0;

    // Reset held two cycles
    tick();
    tick();
    chk("rst_clrPend", clrPend, 1'b1);
    chk("rst_clrIntReg", clrIntReg, 1'b1);
    chk("rst_state", dut.state, 3'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_intDisable", intDisable, 1'b1);
    chk("post_rst_ldIntReg", ldIntReg, 1'b1);
    chk("post_rst_pcLoad", pcLoad, 1'b0);
    chk("post_rst_stall", stall, 1'b0);
    chk("post_rst_inIsr", inIsr, 1'b0);
    chk("post_rst_pcOut", pcOut, 8'h00);
    chk("post_rst_clrPend", clrPend, 1'b0);

    // gie=0: a pending interrupt at every boundary must not be taken
    intPending = 1'b1; isrAddr = 8'h40; instrDone = 1'b1; pcIn = 8'h13;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (stall || pcLoad || dut.state != 3'd0) seen = 1'b1;
    end
    chk("gated_no_ack", seen, 1'b0);

    // EI then DI in the same cycle as a boundary: DI wins and no take
    instrDone = 1'b0; eiExec = 1'b1;
    tick();
    eiExec = 1'b0;
    chk("ei_enables", intDisable, 1'b0);
    diExec = 1'b1; instrDone = 1'b1;
    tick();
    diExec = 1'b0; instrDone = 1'b0;
    chk("di_same_cycle_state", dut.state, 3'd0);
    chk("di_same_cycle_gie_off", intDisable, 1'b1);

    // Re-enable, then hold pending without a boundary
    eiExec = 1'b1;
    tick();
    eiExec = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("no_boundary_wait", dut.state, 3'd0);

    // Basic take at a boundary
    instrDone = 1'b1;
    sb.push_back('{pc: 8'h40, lat: 2});
    tick();
    instrDone = 1'b0;
    chk("ack_stall", stall, 1'b1);
    chk("ack_ldIntReg", ldIntReg, 1'b0);
    chk("ack_intDisable", intDisable, 1'b1);
    chk("ack_pcLoad", pcLoad, 1'b0);
    intPending = 1'b0;
    wait_pcload("vector1");
    chk("vector_clrPend", clrPend, 1'b1);
    chk("vector_clrIntReg", clrIntReg, 1'b1);
    chk("vector_inIsr", inIsr, 1'b1);
    tick();
    chk("isr_clrPend_single", clrPend, 1'b0);
    chk("isr_pcLoad", pcLoad, 1'b0);
    chk("isr_stall", stall, 1'b0);
    chk("isr_inIsr", inIsr, 1'b1);

    // No nesting: new pending request plus DI/EI inside the ISR
    intPending = 1'b1; isrAddr = 8'h60; instrDone = 1'b1; pcIn = 8'h22;
    diExec = 1'b1;
    tick();
    diExec = 1'b0;
    chk("isr_di_intDisable", intDisable, 1'b1);
    eiExec = 1'b1;
    tick();
    eiExec = 1'b0;
    chk("isr_ei_intDisable", intDisable, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (pcLoad) seen = 1'b1;
    end
    chk("no_nesting", seen, 1'b0);

    // RETI: return address restored one cycle later
    instrDone = 1'b0;
    retiExec = 1'b1;
    sb.push_back('{pc: 8'h13, lat: 1});
    tick();
    retiExec = 1'b0;
    wait_pcload("return1");
    chk("return_inIsr", inIsr, 1'b1);
    chk("return_stall", stall, 1'b1);

    // Back in IDLE the still-pending request is taken at the next boundary
    instrDone = 1'b1; pcIn = 8'h25;
    tick();
    chk("idle_intDisable", intDisable, 1'b0);
    chk("idle_inIsr", inIsr, 1'b0);
    sb.push_back('{pc: 8'h60, lat: 2});
    tick();
    instrDone = 1'b0; intPending = 1'b0;
    wait_pcload("vector2");

    // Reset while in VECTOR abandons the ISR
    rst = 1'b1;
    #1;
    chk("mid_rst_clrPend", clrPend, 1'b1);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_state", dut.state, 3'd0);
    chk("mid_rst_inIsr", inIsr, 1'b0);
    chk("mid_rst_pcLoad", pcLoad, 1'b0);
    chk("mid_rst_savedPc", dut.saved_pc, 8'h00);
    chk("mid_rst_intDisable", intDisable, 1'b1);

    // RETI in IDLE is ignored
    retiExec = 1'b1;
    tick();
    retiExec = 1'b0;
    chk("reti_idle_state", dut.state, 3'd0);
    chk("reti_idle_pcLoad", pcLoad, 1'b0);

    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
